// File: rtl/halt_watchdog.sv
// Multi-channel run watchdog: each channel counts cycles from arm until a halt
// rising edge (DONE) or until TIMEOUT cycles elapse (TMO).
module halt_watchdog #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 600000
) (
    input  logic                      clk,
    input  logic                      RST_n,
    input  logic [NUM_CH-1:0]         arm,
    input  logic [NUM_CH-1:0]         clr,
    input  logic [NUM_CH-1:0]         halt,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         tmo,
    output logic [NUM_CH*CNT_W-1:0]   cyc_cnt,
    output logic                      all_done,
    output logic                      any_tmo,
    output logic [2*NUM_CH-1:0]       o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_TMO  = 2'd3;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);

    if (CNT_W < $clog2(TIMEOUT + 1)) begin : g_bad_cnt_w
        $error("halt_watchdog: CNT_W too narrow to hold TIMEOUT");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("halt_watchdog: NUM_CH must be within 1..32");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("halt_watchdog: TIMEOUT must be at least 2");
    end

    logic [NUM_CH-1:0] w_finished;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_halt_q;
        logic             w_halt_edge;

        assign w_halt_edge = halt[i] & ~r_halt_q;

        // halt_q samples in every state so a level already high at arm never
        // looks like a fresh edge.
        always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_halt_q <= 1'b0;
            end else begin
                r_halt_q <= halt[i];
                if (clr[i]) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else if (arm[i]) begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end else if (r_state == ST_RUN) begin
                    if (w_halt_edge) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == TERM_CNT) begin
                        r_state <= ST_TMO;
                        r_cnt   <= TMO_CNT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign busy[i]                       = (r_state == ST_RUN);
        assign done[i]                       = (r_state == ST_DONE);
        assign tmo[i]                        = (r_state == ST_TMO);
        assign cyc_cnt[i*CNT_W +: CNT_W]     = r_cnt;
        assign o_dbg_state[2*i +: 2]         = r_state;
        assign w_finished[i]                 = (r_state == ST_DONE) || (r_state == ST_TMO);
    end

    assign all_done = &w_finished;
    assign any_tmo  = |tmo;

endmodule
